// File: rtl/axis_demux_pkg.sv
// Shared types for the AXI4-Stream route demultiplexer: frame FSM states and route-source codes.
package axis_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam int ROUTE_SEL   = 0;
  localparam int ROUTE_TDEST = 1;

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry register slice: output register plus skid register, with a registered upstream ready.
module axis_skid_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data_r;
  logic [W-1:0] skid_data_s;
  logic [W-1:0] out_data_s;
  logic         skid_valid_r;
  logic         skid_valid_s;
  logic         out_valid_s;
  logic         accept_s;

  assign accept_s = in_valid & in_ready;

  // Next state: the output register refills from the skid entry before taking new input.
  always_comb begin
    out_data_s   = out_data;
    out_valid_s  = out_valid;
    skid_data_s  = skid_data_r;
    skid_valid_s = skid_valid_r;
    if (out_ready || !out_valid) begin
      if (skid_valid_r) begin
        out_data_s   = skid_data_r;
        out_valid_s  = 1'b1;
        skid_valid_s = 1'b0;
      end else if (accept_s) begin
        out_data_s  = in_data;
        out_valid_s = 1'b1;
      end else begin
        out_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_data_s  = in_data;
      skid_valid_s = 1'b1;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Register update; ready stays low through reset and then tracks an empty skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      skid_data_r  <= '0;
      skid_valid_r <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      out_data     <= out_data_s;
      out_valid    <= out_valid_s;
      skid_data_r  <= skid_data_s;
      skid_valid_r <= skid_valid_s;
      in_ready     <= !skid_valid_s;
    end
  end

endmodule

// File: rtl/axis_demux_route.sv
// AXI4-Stream 1:M_COUNT demux with per-frame route latching and per-port skid slices.
// Optional per-port frame / drop statistics are built when AXIS_DEMUX_STATS_EN is defined.
module axis_demux_route
  import axis_demux_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter int ROUTE_MODE  = ROUTE_SEL,
  parameter int SEL_WIDTH   = $clog2(M_COUNT),
  parameter int CNT_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]   m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0] m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  input  logic                          enable,
  input  logic                          drop,
  input  logic [SEL_WIDTH-1:0]          sel,
  output logic [M_COUNT*CNT_WIDTH-1:0]  stat_frames,
  output logic [CNT_WIDTH-1:0]          stat_drops
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int RW = 1 << SEL_WIDTH;

  state_t                 state_r;
  logic [SEL_WIDTH-1:0]   route_r;
  logic                   run_r;
  logic [SEL_WIDTH-1:0]   route_s;
  logic [SEL_WIDTH-1:0]   target_s;
  logic                   bad_s;
  logic                   deliver_s;
  logic                   fire_s;
  logic [M_COUNT-1:0]     slice_ready_s;
  logic [M_COUNT-1:0]     slice_valid_s;
  logic [RW-1:0]          ready_pad_s;
  logic [KEEP_WIDTH-1:0]  keep_s;
  logic [ID_WIDTH-1:0]    id_s;
  logic [DEST_WIDTH-1:0]  dest_s;
  logic [USER_WIDTH-1:0]  user_s;
  logic [PW-1:0]          payload_s;

  assign route_s = (ROUTE_MODE == ROUTE_TDEST) ? SEL_WIDTH'(s_axis_tdest) : sel;
  assign bad_s   = drop
                 | (32'(route_s) >= M_COUNT)
                 | ((ROUTE_MODE == ROUTE_TDEST) && ((s_axis_tdest >> SEL_WIDTH) != '0));

  // Padding lets an out-of-range route index the ready vector safely (it reads 0).
  assign ready_pad_s = RW'(slice_ready_s);
  assign fire_s      = s_axis_tvalid & s_axis_tready;

  assign keep_s    = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b0}};
  assign id_s      = ID_ENABLE   ? s_axis_tid   : {ID_WIDTH{1'b0}};
  assign dest_s    = DEST_ENABLE ? s_axis_tdest : {DEST_WIDTH{1'b0}};
  assign user_s    = USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}};
  assign payload_s = {s_axis_tdata, keep_s, s_axis_tlast, id_s, dest_s, user_s};

  // Upstream ready and beat destination for the current frame state.
  always_comb begin
    target_s      = route_r;
    deliver_s     = 1'b0;
    s_axis_tready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        target_s      = route_s;
        deliver_s     = !bad_s;
        s_axis_tready = run_r & enable & (bad_s | ready_pad_s[route_s]);
      end
      ST_ROUTE: begin
        target_s      = route_r;
        deliver_s     = 1'b1;
        s_axis_tready = run_r & ready_pad_s[route_r];
      end
      ST_DROP: begin
        target_s      = route_r;
        deliver_s     = 1'b0;
        s_axis_tready = run_r;
      end
      default: begin
        target_s      = route_r;
        deliver_s     = 1'b0;
        s_axis_tready = 1'b0;
      end
    endcase
  end

  // Frame FSM: latch the route on the first beat of a multi-beat frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      route_r <= '0;
      run_r   <= 1'b0;
    end else begin
      run_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (fire_s && !s_axis_tlast) begin
            route_r <= route_s;
            state_r <= bad_s ? ST_DROP : ST_ROUTE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ROUTE, ST_DROP: begin
          if (fire_s && s_axis_tlast) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < M_COUNT; i++) begin : g_port
    logic [PW-1:0] out_payload_s;

    assign slice_valid_s[i] = fire_s & deliver_s & (target_s == SEL_WIDTH'(i));

    axis_skid_slice #(.W(PW)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .in_data   (payload_s),
      .in_valid  (slice_valid_s[i]),
      .in_ready  (slice_ready_s[i]),
      .out_data  (out_payload_s),
      .out_valid (m_axis_tvalid[i]),
      .out_ready (m_axis_tready[i])
    );

    assign {m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
            m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
            m_axis_tlast[i],
            m_axis_tid[i*ID_WIDTH +: ID_WIDTH],
            m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
            m_axis_tuser[i*USER_WIDTH +: USER_WIDTH]} = out_payload_s;
  end

`ifdef AXIS_DEMUX_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] frames_r [M_COUNT];
  logic [CNT_WIDTH-1:0] drops_r;
  logic                 drop_last_s;

  assign drop_last_s = fire_s & s_axis_tlast & !deliver_s;

  // Wrapping counters: delivered frames per port and discarded frames overall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M_COUNT; i++) frames_r[i] <= '0;
      drops_r <= '0;
    end else begin
      for (int i = 0; i < M_COUNT; i++) begin
        if (slice_valid_s[i] && s_axis_tlast) frames_r[i] <= frames_r[i] + CNT_ONE;
        else frames_r[i] <= frames_r[i];
      end
      if (drop_last_s) drops_r <= drops_r + CNT_ONE;
      else drops_r <= drops_r;
    end
  end

  for (genvar i = 0; i < M_COUNT; i++) begin : g_stat
    assign stat_frames[i*CNT_WIDTH +: CNT_WIDTH] = frames_r[i];
  end
  assign stat_drops = drops_r;
`else
  assign stat_frames = '0;
  assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_axis_demux_route.sv
// Scoreboard bench: sel-routed 3-port instance under random traffic plus a tdest-routed 4-port instance.
module tb_axis_demux_route;

`ifdef AXIS_DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [7:0]  dst;
    logic        u;
    int          c;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tid, s_tdest;
  logic        s_tuser;
  logic [95:0] m_tdata;
  logic [11:0] m_tkeep;
  logic [2:0]  m_tvalid, m_tready, m_tlast, m_tuser;
  logic [23:0] m_tid, m_tdest;
  logic        enable, drop;
  logic [1:0]  sel;
  logic [47:0] stat_frames;
  logic [15:0] stat_drops;

  logic [31:0]  s1_tdata;
  logic         s1_tvalid, s1_tready, s1_tlast;
  logic [7:0]   s1_tdest;
  logic [127:0] m1_tdata;
  logic [15:0]  m1_tkeep;
  logic [3:0]   m1_tvalid, m1_tlast, m1_tuser;
  logic [31:0]  m1_tid, m1_tdest;
  logic [127:0] s1_frames;
  logic [31:0]  s1_drops;

  int    tests = 0, fails = 0, cyc = 0;
  int    acc_count = 0, n_stall = 0;
  int    exp_frames [3];
  int    exp_drops = 0;
  bit    rnd_ready = 1'b0, chk_lat = 1'b0;
  logic [2:0] force_ready = 3'b111;
  beat_t q [3][$];
  logic [39:0] q1 [$];

  axis_demux_route #(.M_COUNT(3), .DATA_WIDTH(32), .DEST_ENABLE(1'b1), .ROUTE_MODE(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .enable(enable), .drop(drop), .sel(sel), .stat_frames(stat_frames), .stat_drops(stat_drops));

  axis_demux_route #(.M_COUNT(4), .DATA_WIDTH(32), .DEST_ENABLE(1'b1), .ROUTE_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_tdata), .s_axis_tkeep(4'hF), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .s_axis_tlast(s1_tlast), .s_axis_tid(8'h00), .s_axis_tdest(s1_tdest), .s_axis_tuser(1'b0),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid), .m_axis_tready(4'hF),
    .m_axis_tlast(m1_tlast), .m_axis_tid(m1_tid), .m_axis_tdest(m1_tdest), .m_axis_tuser(m1_tuser),
    .enable(1'b1), .drop(1'b0), .sel(2'd0), .stat_frames(s1_frames), .stat_drops(s1_drops));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = rnd_ready ? 3'($urandom) : force_ready;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Output monitor for the sel-routed instance: every handshake pops that port's expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (m_tvalid[i] && m_tready[i]) begin
          if (q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat port %0d: got data %h expected no beat", i, m_tdata[i*32 +: 32]);
          end else begin
            beat_t e;
            e = q[i].pop_front();
            chk($sformatf("beat_port%0d", i),
                {10'd0, m_tdata[i*32 +: 32], m_tkeep[i*4 +: 4], m_tlast[i], m_tid[i*8 +: 8], m_tdest[i*8 +: 8], m_tuser[i]},
                {10'd0, e.d, e.k, e.l, 8'h00, e.dst, e.u});
            if (chk_lat) chk($sformatf("latency_port%0d", i), 64'(cyc), 64'(e.c + 1));
          end
        end
      end
    end
  end

  // Output monitor for the tdest-routed instance: only port 1 may ever present data.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (m1_tvalid[i]) begin
          if (i != 1 || q1.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tdest_unexpected port %0d: got data %h expected no beat", i, m1_tdata[i*32 +: 32]);
          end else begin
            chk("tdest_beat", {24'd0, m1_tdest[15:8], m1_tdata[63:32]}, {24'd0, q1.pop_front()});
          end
        end
      end
    end
  end

  task automatic drive_beat(input logic [1:0] s, input logic d, input bit first, input bit bad,
                            input bit last, input bit rnd_en, input logic [31:0] data);
    int  waited = 0;
    bit  done = 1'b0;
    beat_t e;
    s_tdata  = data;
    s_tlast  = last;
    s_tkeep  = 4'($urandom);
    s_tdest  = 8'($urandom);
    s_tuser  = 1'($urandom);
    s_tid    = 8'($urandom);
    s_tvalid = 1'b1;
    while (!done) begin
      if (first) begin
        sel    = s;
        drop   = d;
        enable = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        sel    = 2'($urandom);
        drop   = 1'($urandom);
        enable = 1'($urandom);
      end
      @(negedge clk);
      if (bad && (!first || enable)) chk("bad_frame_tready", 64'(s_tready), 64'd1);
      if (s_tready) begin
        done = 1'b1;
        acc_count++;
        if (!bad) begin
          e.d = data; e.k = s_tkeep; e.l = last; e.dst = s_tdest; e.u = s_tuser; e.c = cyc;
          q[int'(s)].push_back(e);
          if (last) exp_frames[int'(s)]++;
        end else if (last) begin
          exp_drops++;
        end
      end else begin
        n_stall++;
        waited++;
      end
      @(posedge clk);
      #1;
      if (waited > 300) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: got no tready in %0d cycles expected a handshake", waited);
        done = 1'b1;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [1:0] s, input logic d, input bit rnd_en,
                            input bit fixed, input logic [31:0] base);
    bit bad = d || (s >= 2'd3);
    for (int b = 0; b < len; b++)
      drive_beat(s, d, b == 0, bad, b == len - 1, rnd_en, fixed ? base + 32'(b) : $urandom);
  endtask

  task automatic drain();
    rnd_ready   = 1'b0;
    force_ready = 3'b111;
    for (int k = 0; k < 200 && (q[0].size() + q[1].size() + q[2].size()) != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
  endtask

  task automatic check_stats();
    for (int i = 0; i < 3; i++)
      chk($sformatf("stat_frames%0d", i), 64'(stat_frames[i*16 +: 16]), STATS ? 64'(16'(exp_frames[i])) : 64'd0);
    chk("stat_drops", 64'(stat_drops), STATS ? 64'(16'(exp_drops)) : 64'd0);
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 3; i++) exp_frames[i] = 0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tid = '0; s_tdest = '0; s_tuser = 1'b0;
    enable = 1'b1; drop = 1'b1; sel = 2'd0; m_tready = 3'b111;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0; s1_tdest = '0;
    repeat (2) @(negedge clk);
    chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset_s_tready", 64'(s_tready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_stats();

    // Latency, mid-frame sel changes and a back-to-back follow-up frame.
    rnd_ready = 1'b0; force_ready = 3'b111; chk_lat = 1'b1;
    @(posedge clk);
    #1;
    n_stall = 0;
    send_frame(3, 2'd2, 1'b0, 1'b0, 1'b1, 32'hA0);
    send_frame(2, 2'd1, 1'b0, 1'b0, 1'b1, 32'hB0);
    chk("no_bubble_stalls", 64'(n_stall), 64'd0);
    drain();
    chk_lat = 1'b0;

    // Out-of-range route is swallowed one beat per cycle.
    send_frame(4, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    drain();

    // A stalled port fills its two slice entries then throttles the input.
    force_ready = 3'b110;
    @(posedge clk);
    #1;
    a0 = acc_count;
    fork
      send_frame(5, 2'd0, 1'b0, 1'b0, 1'b1, 32'h50);
      begin
        repeat (6) @(posedge clk);
        #3;
        chk("stall_s_tready", 64'(s_tready), 64'd0);
        chk("stall_beats_taken", 64'(acc_count - a0), 64'd2);
        force_ready = 3'b111;
      end
    join
    drain();
    check_stats();

    // Random traffic with random downstream backpressure.
    rnd_ready = 1'b1;
    repeat (150)
      send_frame($urandom_range(1, 6), 2'($urandom), $urandom_range(0, 7) == 0, 1'b1, 1'b0, 32'h0);
    drain();
    check_stats();

    // Reset in the middle of a frame on port 2.
    drive_beat(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hD0);
    drive_beat(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hD1);
    drive_beat(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hD2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("async_reset_s_tready", 64'(s_tready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      exp_frames[i] = 0;
    end
    exp_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send_frame(2, 2'd0, 1'b0, 1'b0, 1'b1, 32'hE0);
    drain();
    chk_lat = 1'b0;
    check_stats();

    // tdest routing: 0x01 reaches port 1, 0x11 has non-zero upper bits and is dropped.
    for (int k = 0; k < 4; k++) begin
      s1_tdata  = (k < 2) ? 32'hB0 + 32'(k) : 32'hC0 + 32'(k - 2);
      s1_tdest  = (k < 2) ? 8'h01 : 8'h11;
      s1_tlast  = (k % 2) == 1;
      s1_tvalid = 1'b1;
      if (k < 2) q1.push_back({8'h01, s1_tdata});
      @(negedge clk);
      chk("tdest_s_tready", 64'(s1_tready), 64'd1);
      @(posedge clk);
      #1;
    end
    s1_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("tdest_all_delivered", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
